// File: rtl/mac_bist_controller.sv
// BIST sequencer for the MAC: walks the pattern ROM, issues one MAC operation per
// pattern, compares each result with the ROM golden value and reports pass/fail.
module mac_bist_controller #(
  parameter int unsigned NUM_PATTERNS   = 16,
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_PATTERNS),
  parameter int unsigned FIRST_ADDR     = 1,
  parameter int unsigned LAST_ADDR      = 5,
  parameter int unsigned P_WIDTH        = 32,
  parameter int unsigned MAC_LATENCY    = 2,
  parameter int unsigned FAIL_CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic signed [P_WIDTH-1:0]   rom_expected_p,
  input  logic signed [P_WIDTH-1:0]   mac_result,
  output logic                        bist_mode,
  output logic                        mac_in_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [FAIL_CNT_WIDTH-1:0]   fail_count,
  output logic                        first_fail_valid,
  output logic [ADDR_WIDTH-1:0]       first_fail_addr
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                      state, state_d;
  logic [ADDR_WIDTH-1:0]       rom_addr_d;
  logic                        bist_mode_d, mac_in_valid_d, busy_d, done_d, pass_d;
  logic [FAIL_CNT_WIDTH-1:0]   fail_count_d;
  logic                        first_fail_valid_d;
  logic [ADDR_WIDTH-1:0]       first_fail_addr_d;
  logic signed [P_WIDTH-1:0]   exp_reg, exp_reg_d;
  logic [CNT_W-1:0]            cnt, cnt_d;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rom_addr         <= '0;
      bist_mode        <= 1'b0;
      mac_in_valid     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_addr  <= '0;
      exp_reg          <= '0;
      cnt              <= '0;
    end else begin
      state            <= state_d;
      rom_addr         <= rom_addr_d;
      bist_mode        <= bist_mode_d;
      mac_in_valid     <= mac_in_valid_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      fail_count       <= fail_count_d;
      first_fail_valid <= first_fail_valid_d;
      first_fail_addr  <= first_fail_addr_d;
      exp_reg          <= exp_reg_d;
      cnt              <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d            = state;
    rom_addr_d         = rom_addr;
    bist_mode_d        = bist_mode;
    mac_in_valid_d     = 1'b0;
    busy_d             = busy;
    done_d             = done;
    pass_d             = pass;
    fail_count_d       = fail_count;
    first_fail_valid_d = first_fail_valid;
    first_fail_addr_d  = first_fail_addr;
    exp_reg_d          = exp_reg;
    cnt_d              = cnt;

    if (abort) begin
      // Results are deliberately kept so test logic can still read them
      state_d     = S_IDLE;
      rom_addr_d  = '0;
      bist_mode_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d            = S_APPLY;
            rom_addr_d         = ADDR_WIDTH'(FIRST_ADDR);
            bist_mode_d        = 1'b1;
            mac_in_valid_d     = 1'b1;
            busy_d             = 1'b1;
            done_d             = 1'b0;
            pass_d             = 1'b0;
            fail_count_d       = '0;
            first_fail_valid_d = 1'b0;
            first_fail_addr_d  = '0;
          end
        end
        S_APPLY: begin
          exp_reg_d = rom_expected_p;
          cnt_d     = CNT_W'(MAC_LATENCY);
          state_d   = (MAC_LATENCY == 0) ? S_COMPARE : S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_d = S_COMPARE;
        end
        S_COMPARE: begin
          if (mac_result != exp_reg) begin
            if (fail_count != '1) fail_count_d = fail_count + FAIL_CNT_WIDTH'(1);
            if (!first_fail_valid) begin
              first_fail_valid_d = 1'b1;
              first_fail_addr_d  = rom_addr;
            end
          end
          if (rom_addr == ADDR_WIDTH'(LAST_ADDR)) begin
            state_d     = S_DONE;
            rom_addr_d  = '0;
            bist_mode_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = (fail_count_d == '0);
          end else begin
            state_d        = S_APPLY;
            rom_addr_d     = rom_addr + ADDR_WIDTH'(1);
            mac_in_valid_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
